// File: rtl/aes_enc_iter_ctrl.sv
// rtl/aes_enc_iter_ctrl.sv - iterative AES-128 encryption sequencer around external round units
module aes_enc_iter_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   rnd_rc,
    output logic [127:0] rnd_data,
    output logic [127:0] rnd_key,
    input  logic [127:0] rnd_keyout,
    input  logic [127:0] rnd_out,
    input  logic [127:0] lst_out
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q,   fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q,   key_d;
    logic [3:0]   cnt_q,   cnt_d;

    // Sequencer registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load with AddRoundKey, run rounds 1..NR-1 on the
    // full-round unit, the last round on the final-round unit, then hold.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ in_key;
                    key_d   = in_key;
                    cnt_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                key_d = rnd_keyout;
                if (cnt_q < LAST_RND) begin
                    state_d = rnd_out;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    // Any count at or beyond the last round finishes here,
                    // so the counter can never run past NR.
                    state_d = lst_out;
                    cnt_d   = 4'd0;
                    fsm_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = 4'd0;
            end
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
    assign rnd_rc    = (fsm_q == RUN) ? cnt_q : 4'd0;
    assign rnd_data  = state_q;
    assign rnd_key   = key_q;
    assign out_data  = state_q;

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// tb/tb_aes_enc_iter_ctrl.sv - self-checking bench for aes_enc_iter_ctrl with behavioural AES round units
module tb_aes_enc_iter_ctrl;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   rnd_rc;
    logic [127:0] rnd_data;
    logic [127:0] rnd_key;
    logic [127:0] rnd_keyout;
    logic [127:0] rnd_out;
    logic [127:0] lst_out;

    int checks = 0;
    int errors = 0;

    logic [3:0]   rc_log[$];
    logic [127:0] first_rd;
    logic [127:0] first_rk;

    always #5 clk = ~clk;

    aes_enc_iter_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .rnd_rc     (rnd_rc),
        .rnd_data   (rnd_data),
        .rnd_key    (rnd_key),
        .rnd_keyout (rnd_keyout),
        .rnd_out    (rnd_out),
        .lst_out    (lst_out)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  sq = x;
        logic [7:0]  inv = 8'h01;
        logic [15:0] d;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] v = 8'h01;
        if (rc == 4'd0) return 8'h00;
        for (int i = 1; i < 11; i++) begin
            if (i == int'(rc)) return v;
            v = xtime(v);
        end
        return 8'h00;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [3:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(rc), 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        for (int r = 1; r <= 10; r++) begin
            k = key_expand(k, 4'(r));
            if (r < 10) s = mix_columns(shift_rows(sub_bytes(s))) ^ k;
            else        s = shift_rows(sub_bytes(s)) ^ k;
        end
        return s;
    endfunction

    // Combinational round units attached to the sequencer.
    always_comb begin
        rnd_keyout = key_expand(rnd_key, rnd_rc);
        lst_out    = shift_rows(sub_bytes(rnd_data)) ^ rnd_keyout;
        rnd_out    = mix_columns(shift_rows(sub_bytes(rnd_data))) ^ rnd_keyout;
    end

    // Called at a falling edge; accepts one block and waits for out_valid.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit garbage,
                             output int lat, output logic [127:0] ct);
        int k = 0;
        rc_log.delete();
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        first_rd = rnd_data;
        first_rk = rnd_key;
        rc_log.push_back(rnd_rc);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            rc_log.push_back(rnd_rc);
            if (garbage) begin
                in_valid = 1'($urandom);
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_key   = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        ct = out_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_key = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rnd_rc !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b rnd_rc=%0d, need 1 0 0 0",
                     in_ready, out_valid, busy, rnd_rc);
        end
        checks++;
        if (out_data !== 128'h0 || rnd_data !== 128'h0 || rnd_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs: out_data=%h rnd_key=%h, need 0", out_data, rnd_key);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vector_b;
        int lat;
        logic [127:0] ct;
        out_ready = 1'b1;
        run_block(PT_B, KEY_B, 1'b0, lat, ct);
        checks++;
        if (ct !== CT_B) begin
            errors++;
            $display("FAIL vec_b_ct: got %h need %h", ct, CT_B);
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL vec_b_latency: got %0d need 10", lat);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL vec_b_one_cycle: out_valid=%b in_ready=%b busy=%b, need 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_vector_c1;
        int lat;
        logic [127:0] ct;
        int bad = 0;
        out_ready = 1'b1;
        run_block(PT_C, KEY_C, 1'b0, lat, ct);
        checks++;
        if (ct !== CT_C) begin
            errors++;
            $display("FAIL vec_c1_ct: got %h need %h", ct, CT_C);
        end
        checks++;
        if (first_rd !== (PT_C ^ KEY_C) || first_rk !== KEY_C) begin
            errors++;
            $display("FAIL vec_c1_load: rnd_data=%h rnd_key=%h need %h %h",
                     first_rd, first_rk, PT_C ^ KEY_C, KEY_C);
        end
        checks++;
        if (rc_log.size() != 11) begin
            bad = 1;
        end else begin
            for (int i = 0; i < 11; i++)
                if (int'(rc_log[i]) != ((i < 10) ? i + 1 : 0)) bad = 1;
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL vec_c1_rc_seq: got %p need 1..10 then 0", rc_log);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [127:0] ct, ct2;
        logic [127:0] exp_ct;
        int bad = 0;
        logic [127:0] pt  = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = aes_ref(pt, key);
        out_ready = 1'b0;
        run_block(pt, key, 1'b0, lat, ct);
        checks++;
        if (ct !== exp_ct) begin
            errors++;
            $display("FAIL bp_ct: got %h need %h", ct, exp_ct);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (out_data !== exp_ct || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d cycles with out_data/out_valid/in_ready/busy changed, need 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        run_block(PT_C, KEY_C, 1'b0, lat, ct2);
        checks++;
        if (ct2 !== CT_C || lat !== 10) begin
            errors++;
            $display("FAIL bp_next_block: ct=%h lat=%0d need %h 10", ct2, lat, CT_C);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acc[$];
        logic [127:0] ctq[$];
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (acc.size() < 2);
            in_data  = (acc.size() == 0) ? PT_B : PT_C;
            in_key   = (acc.size() == 0) ? KEY_B : KEY_C;
            if (in_ready && in_valid) acc.push_back(cyc);
            @(negedge clk);
            if (out_valid) ctq.push_back(out_data);
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 2 || (acc[1] - acc[0]) != 12) begin
            errors++;
            $display("FAIL b2b_spacing: %0d accepts, spacing %0d, need 2 and 12",
                     acc.size(), (acc.size() == 2) ? acc[1] - acc[0] : -1);
        end
        checks++;
        if (ctq.size() != 2 || ctq[0] !== CT_B || ctq[1] !== CT_C) begin
            errors++;
            $display("FAIL b2b_ct: %0d results, need 2 (%h, %h)", ctq.size(), CT_B, CT_C);
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        int seen = 0;
        int lat;
        logic [127:0] ct;
        out_ready = 1'b1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1; in_data = PT_C; in_key = KEY_C;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (rnd_rc !== 4'd5 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rnd_rc !== 4'd5) begin
            errors++;
            $display("FAIL rst_mid_reach: rnd_rc=%0d need 5", rnd_rc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || rnd_rc !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_abort: busy=%b out_valid=%b rnd_rc=%0d in_ready=%b, need 0 0 0 1",
                     busy, out_valid, rnd_rc, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: %0d cycles with activity after reset, need 0", seen);
        end
        run_block(PT_B, KEY_B, 1'b0, lat, ct);
        checks++;
        if (ct !== CT_B || lat !== 10) begin
            errors++;
            $display("FAIL rst_mid_fresh: ct=%h lat=%0d need %h 10", ct, lat, CT_B);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_input;
        int lat;
        logic [127:0] ct;
        out_ready = 1'b1;
        run_block(PT_B, KEY_B, 1'b1, lat, ct);
        checks++;
        if (ct !== CT_B || lat !== 10) begin
            errors++;
            $display("FAIL busy_input: ct=%h lat=%0d need %h 10", ct, lat, CT_B);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat;
        logic [127:0] ct, pt, key;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_block(pt, key, 1'b0, lat, ct);
            checks++;
            if (ct !== aes_ref(pt, key) || lat !== 10) begin
                errors++;
                $display("FAIL random_%0d: ct=%h lat=%0d need %h 10", n, ct, lat, aes_ref(pt, key));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vector_b();
        test_vector_c1();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_busy_input();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
